// File: rtl/dma_desc_bypass_issuer_if.sv
// Command and descriptor-bypass signal bundle for dma_desc_bypass_issuer.
// The slave modport is the issuer's view; master is the user/DMA-driver side.
interface dma_desc_bypass_issuer_if;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [63:0] s_cmd_addr;
    logic [31:0] s_cmd_len;
    logic        dsc_byp_ready;
    logic        dsc_byp_load;
    logic [63:0] dsc_byp_addr;
    logic [31:0] dsc_byp_len;
    logic        data_last;

    modport master (
        output s_cmd_valid, s_cmd_addr, s_cmd_len, dsc_byp_ready, data_last,
        input  s_cmd_ready, dsc_byp_load, dsc_byp_addr, dsc_byp_len
    );

    modport slave (
        input  s_cmd_valid, s_cmd_addr, s_cmd_len, dsc_byp_ready, data_last,
        output s_cmd_ready, dsc_byp_load, dsc_byp_addr, dsc_byp_len
    );
endinterface

// File: rtl/dma_desc_bypass_issuer.sv
// Splits host transfer commands at MAX_DESC_LEN boundaries into XDMA bypass descriptors,
// issued under a credit limit. Optional statistics counters: define DMA_DESC_STATS_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | s_cmd_ready high, waiting for a command
// ISSUE | emitting one descriptor per cycle while ready and credit hold
module dma_desc_bypass_issuer #(
    parameter int unsigned MAX_DESC_LEN = 4096,
    parameter int unsigned OUTSTANDING  = 8
) (
    input  logic                          pcie_clk,
    input  logic                          pcie_aresetn,
    dma_desc_bypass_issuer_if.slave       bus,
    output logic [$clog2(OUTSTANDING):0]  outstanding,
    output logic                          busy,
    output logic                          cmd_done,
    output logic                          err,
    output logic [31:0]                   desc_count,
    output logic [31:0]                   cmd_count
);

    localparam int OFF_W = $clog2(MAX_DESC_LEN);
    localparam int OCW   = $clog2(OUTSTANDING) + 1;
    localparam int PW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                 state;
    logic                   ready_q;
    logic [63:0]            cur_addr;
    logic [31:0]            rem;
    logic [OUTSTANDING-1:0] last_fifo;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;

    logic [OFF_W-1:0]       offset;
    logic [31:0]            space;
    logic [31:0]            chunk;
    logic                   last_chunk;
    logic                   load;
    logic                   pop;
    logic                   cmd_fire;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Room left before the next MAX_DESC_LEN-aligned boundary.
    assign offset     = cur_addr[OFF_W-1:0];
    assign space      = 32'(MAX_DESC_LEN) - 32'(offset);
    assign chunk      = (rem < space) ? rem : space;
    assign last_chunk = (rem == chunk);

    assign load     = (state == ST_ISSUE) && bus.dsc_byp_ready && (outstanding < OCW'(OUTSTANDING));
    assign pop      = bus.data_last && (outstanding != '0);
    assign cmd_fire = bus.s_cmd_valid && ready_q;

    assign bus.s_cmd_ready  = ready_q;
    assign bus.dsc_byp_load = load;
    assign bus.dsc_byp_addr = cur_addr;
    assign bus.dsc_byp_len  = chunk;

    assign busy = (state != ST_IDLE) || (outstanding != '0);

    always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            state       <= ST_IDLE;
            ready_q     <= 1'b0;
            cur_addr    <= '0;
            rem         <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cmd_done    <= 1'b0;
            err         <= 1'b0;
        end else begin
            cmd_done <= pop && last_fifo[rd_ptr];

            if (bus.data_last && (outstanding == '0))
                err <= 1'b1;

            unique case ({load, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (load) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);

            unique case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_fire) begin
                        if (bus.s_cmd_len == '0) begin
                            err <= 1'b1;
                        end else begin
                            cur_addr <= bus.s_cmd_addr;
                            rem      <= bus.s_cmd_len;
                            state    <= ST_ISSUE;
                            ready_q  <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (load) begin
                        cur_addr <= cur_addr + 64'(chunk);
                        rem      <= rem - chunk;
                        if (last_chunk) begin
                            state   <= ST_IDLE;
                            ready_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Last-descriptor flags; the credit limit keeps this from ever overflowing.
    always_ff @(posedge pcie_clk) begin
        if (load)
            last_fifo[wr_ptr] <= last_chunk;
    end

`ifdef DMA_DESC_STATS_EN
    always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            desc_count <= '0;
            cmd_count  <= '0;
        end else begin
            if (load)     desc_count <= desc_count + 1'b1;
            if (cmd_done) cmd_count  <= cmd_count + 1'b1;
        end
    end
`else
    assign desc_count = '0;
    assign cmd_count  = '0;
`endif

endmodule

// File: tb/tb_dma_desc_bypass_issuer.sv
// Bench for dma_desc_bypass_issuer: command table plus credit, back-pressure,
// error and reset sequences, with a descriptor scoreboard fed by a split model.
`timescale 1ns/1ps
module tb_dma_desc_bypass_issuer;

    localparam int MDL = 4096;
    localparam int OUT = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  outstanding;
    logic        busy, cmd_done, err;
    logic [31:0] desc_count, cmd_count;

    always #5 clk = ~clk;

    dma_desc_bypass_issuer_if bus();

    dma_desc_bypass_issuer #(.MAX_DESC_LEN(MDL), .OUTSTANDING(OUT)) dut (
        .pcie_clk    (clk),
        .pcie_aresetn(rst_n),
        .bus         (bus),
        .outstanding (outstanding),
        .busy        (busy),
        .cmd_done    (cmd_done),
        .err         (err),
        .desc_count  (desc_count),
        .cmd_count   (cmd_count)
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        logic        last;
    } desc_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        int          exp_n;
    } vec_t;

    desc_t sb_q[$];
    logic  exp_last_q[$];
    desc_t mon_d;
    vec_t  vecs[6];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_loads  = 0;
    int    n_done   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Expected descriptors: split at 4 KiB boundaries.
    task automatic push_model(input logic [63:0] a, input logic [31:0] len);
        logic [63:0] cur;
        logic [31:0] rem, space, c;
        cur = a;
        rem = len;
        while (rem != 0) begin
            space = 32'h1000 - {20'h0, cur[11:0]};
            c     = (rem < space) ? rem : space;
            sb_q.push_back('{cur, c, (rem == c)});
            cur = cur + {32'h0, c};
            rem = rem - c;
        end
    endtask

    always @(negedge clk) begin
        if (bus.dsc_byp_load === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_load: got load addr=0x%0h len=0x%0h, want no load",
                         bus.dsc_byp_addr, bus.dsc_byp_len);
            end else begin
                mon_d = sb_q.pop_front();
                check("desc_addr", bus.dsc_byp_addr, mon_d.addr);
                check("desc_len", {32'h0, bus.dsc_byp_len}, {32'h0, mon_d.len});
                exp_last_q.push_back(mon_d.last);
                n_loads++;
            end
        end
    end

    // Called away from an edge; returns at the negedge after data_last was sampled.
    task automatic pulse_last();
        logic exp_done;
        exp_done = (exp_last_q.size() > 0) ? exp_last_q.pop_front() : 1'b0;
        bus.data_last = 1'b1;
        @(posedge clk); #1;
        bus.data_last = 1'b0;
        @(negedge clk);
        check("cmd_done", cmd_done, exp_done);
        if (exp_done) n_done++;
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [31:0] len);
        int waited;
        waited = 0;
        bus.s_cmd_valid = 1'b1;
        bus.s_cmd_addr  = a;
        bus.s_cmd_len   = len;
        forever begin
            @(negedge clk);
            if (bus.s_cmd_ready === 1'b1) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                $display("FAIL cmd_accept_timeout: got s_cmd_ready=0 for 50 cycles, want 1");
                break;
            end
        end
        push_model(a, len);
        @(posedge clk); #1;
        bus.s_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (sb_q.size() == 0 && exp_last_q.size() == 0) break;
            if (exp_last_q.size() > 0) pulse_last();
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_sb_empty", sb_q.size(), 0);
        check("drain_outstanding", outstanding, 0);
        check("drain_busy", busy, 0);
        check("drain_ready", bus.s_cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n             = 1'b0;
        bus.s_cmd_valid   = 1'b0;
        bus.s_cmd_addr    = '0;
        bus.s_cmd_len     = '0;
        bus.dsc_byp_ready = 1'b1;
        bus.data_last     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb_q.delete();
        exp_last_q.delete();
        n_loads = 0;
        n_done  = 0;
        rst_n   = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", bus.s_cmd_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after_first_edge", bus.s_cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_stats();
        logic [31:0] exp_dc, exp_cc;
`ifdef DMA_DESC_STATS_EN
        exp_dc = 32'(n_loads);
        exp_cc = 32'(n_done);
`else
        exp_dc = '0;
        exp_cc = '0;
`endif
        check("desc_count", desc_count, exp_dc);
        check("cmd_count", cmd_count, exp_cc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l0, iters;

        vecs[0] = '{64'h1000, 32'h1000, 1};
        vecs[1] = '{64'h1F00, 32'h1300, 3};
        vecs[2] = '{64'h0FFF, 32'h2, 2};
        vecs[3] = '{64'h2000, 32'h1, 1};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_F800, 32'h1000, 2};
        vecs[5] = '{64'h10, 32'h2000, 3};

        bus.s_cmd_valid   = 1'b0;
        bus.s_cmd_addr    = '0;
        bus.s_cmd_len     = '0;
        bus.dsc_byp_ready = 1'b1;
        bus.data_last     = 1'b0;

        @(negedge clk);
        check("rst_ready", bus.s_cmd_ready, 0);
        check("rst_load", bus.dsc_byp_load, 0);
        check("rst_addr", bus.dsc_byp_addr, 0);
        check("rst_len", bus.dsc_byp_len, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_done", cmd_done, 0);
        check("rst_err", err, 0);
        check_stats();
        apply_reset();

        // Table of commands: descriptor count, first-load latency, back-to-back issue.
        for (int i = 0; i < 6; i++) begin
            l0 = n_loads;
            send_cmd(vecs[i].addr, vecs[i].len);
            iters = 0;
            for (int k = 0; k < 30; k++) begin
                @(posedge clk); #1;
                iters++;
                if (n_loads - l0 >= vecs[i].exp_n) break;
            end
            check("vec_ndesc", 64'(n_loads - l0), 64'(vecs[i].exp_n));
            check("vec_cycles", 64'(iters), 64'(vecs[i].exp_n));
            @(negedge clk);
            check("vec_outstanding", outstanding, 4'(vecs[i].exp_n));
            check("vec_no_extra_load", bus.dsc_byp_load, 0);
            drain();
        end
        check("err_clean", err, 0);
        repeat (2) @(posedge clk);
        #1;
        check_stats();

        // Credit limit: 10 chunks, no completions.
        send_cmd(64'h0, 32'd40960);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("credit_b2b_load", bus.dsc_byp_load, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("credit_stall_load", bus.dsc_byp_load, 0);
        check("credit_full", outstanding, 8);
        check("credit_hold_addr", bus.dsc_byp_addr, 64'h8000);
        @(posedge clk); #1;
        @(negedge clk);
        check("credit_still_stalled", bus.dsc_byp_load, 0);
        pulse_last();
        check("credit_ninth_load", bus.dsc_byp_load, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("credit_refull", outstanding, 8);
        check("credit_stall2_load", bus.dsc_byp_load, 0);
        check("credit_hold_addr2", bus.dsc_byp_addr, 64'h9000);
        @(posedge clk); #1;
        drain();

        // Bypass ready held low mid-command.
        l0 = n_loads;
        send_cmd(64'h0, 32'h3000);
        @(negedge clk);
        check("bp_first_load", bus.dsc_byp_load, 1);
        @(posedge clk); #1;
        bus.dsc_byp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_no_load", bus.dsc_byp_load, 0);
            check("bp_addr_stable", bus.dsc_byp_addr, 64'h1000);
            check("bp_len_stable", bus.dsc_byp_len, 32'h1000);
            @(posedge clk); #1;
        end
        bus.dsc_byp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (n_loads - l0 >= 3) break;
        end
        check("bp_total_loads", 64'(n_loads - l0), 3);
        drain();

        // Load and data_last in the same cycle.
        send_cmd(64'h0, 32'h2000);
        @(negedge clk);
        check("sim_first_load", bus.dsc_byp_load, 1);
        @(posedge clk); #1;
        bus.data_last = 1'b1;
        @(negedge clk);
        check("sim_second_load", bus.dsc_byp_load, 1);
        check("sim_out_before", outstanding, 1);
        @(posedge clk); #1;
        bus.data_last = 1'b0;
        if (exp_last_q.size() > 0) void'(exp_last_q.pop_front());
        @(negedge clk);
        check("sim_out_unchanged", outstanding, 1);
        check("sim_cmd_done", cmd_done, 0);
        check("sim_err", err, 0);
        @(posedge clk); #1;
        drain();

        // Reset during the second descriptor of a 3-chunk command.
        send_cmd(64'h1F00, 32'h1300);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_load", bus.dsc_byp_load, 0);
        check("midrst_addr", bus.dsc_byp_addr, 0);
        check("midrst_len", bus.dsc_byp_len, 0);
        check("midrst_outstanding", outstanding, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", bus.s_cmd_ready, 0);
        check("midrst_cmd_done", cmd_done, 0);
        check("midrst_err", err, 0);
        check_stats();
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("postrst_no_load", bus.dsc_byp_load, 0);
            @(posedge clk); #1;
        end

        // data_last with nothing outstanding.
        bus.data_last = 1'b1;
        @(posedge clk); #1;
        bus.data_last = 1'b0;
        @(negedge clk);
        check("orphan_err", err, 1);
        check("orphan_outstanding", outstanding, 0);
        check("orphan_cmd_done", cmd_done, 0);
        @(posedge clk); #1;
        apply_reset();
        @(negedge clk);
        check("err_cleared_by_reset", err, 0);
        @(posedge clk); #1;

        // Zero-length command, then a normal command: err must stay set.
        send_cmd(64'h5000, 32'h0);
        @(negedge clk);
        check("zlen_err", err, 1);
        check("zlen_ready", bus.s_cmd_ready, 1);
        check("zlen_load", bus.dsc_byp_load, 0);
        check("zlen_busy", busy, 0);
        @(posedge clk); #1;
        send_cmd(64'h0, 32'h100);
        drain();
        check("err_sticky", err, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
